// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator hall-call dispatcher.
//   FLOOR_W / NUM_FLOORS : floor number width and pending-mask size
//   floor_t, car_id_t    : floor number and car selector types
//   dispatch_state_t     : dispatcher FSM states
//   DROP_MAX             : saturation value of the rejected-call counter
package elevator_pkg;

  localparam int FLOOR_W    = 3;
  localparam int NUM_FLOORS = 8;
  localparam int DROP_MAX   = 255;

  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic               car_id_t;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    ISSUE
  } dispatch_state_t;

endpackage

// File: rtl/elevator_dispatch_scheduler_floor_rr_picker.sv
// Round-robin floor picker (combinational).
// Finds the first set bit of the pending mask, searching upward from
// rr_ptr_i+1 and wrapping from the top floor back to floor 1. Bit 0
// ("no floor") is never considered.
//   pend_i    in  NUM_FLOORS  pending-call mask
//   rr_ptr_i  in  FLOOR_W     last served floor (0 after reset)
//   found_o   out 1           a pending floor exists
//   floor_o   out FLOOR_W     selected floor (0 when nothing found)
module floor_rr_picker #(
  parameter int FLOOR_W    = 3,
  parameter int NUM_FLOORS = 8
) (
  input  logic [NUM_FLOORS-1:0] pend_i,
  input  logic [FLOOR_W-1:0]    rr_ptr_i,
  output logic                  found_o,
  output logic [FLOOR_W-1:0]    floor_o
);

  logic [FLOOR_W:0] cand;
  logic             hit;

  always_comb begin
    hit     = 1'b0;
    floor_o = '0;
    cand    = '0;
    for (int k = 1; k < NUM_FLOORS; k++) begin
      // Candidate floor rr_ptr+k folded into the range 1..NUM_FLOORS-1.
      cand = {1'b0, rr_ptr_i} + (FLOOR_W+1)'(k);
      if (cand > (FLOOR_W+1)'(NUM_FLOORS-1)) begin
        cand = cand - (FLOOR_W+1)'(NUM_FLOORS-1);
      end
      if (!hit && pend_i[cand[FLOOR_W-1:0]]) begin
        hit     = 1'b1;
        floor_o = cand[FLOOR_W-1:0];
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/elevator_dispatch_scheduler.sv
// Hall-call dispatcher for two elevator cars.
// Buffers hall calls as a per-floor mask, picks the next floor round-robin
// and offers it to the nearest eligible (idle, not overweight) car over a
// valid/ready handshake.
//   clk, rst                     clock, async active-high reset
//   call_valid/call_floor/call_ready   hall-call input (always accepted)
//   carN_floor/carN_idle/carN_over_weight   car status
//   dispatch_valid/car/floor/ready     assignment output handshake
//   pending                      registered pending-call mask
//   drop_count                   saturating count of floor-0 calls
module elevator_dispatch_scheduler #(
  parameter int FLOOR_W    = 3,
  parameter int NUM_FLOORS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  output logic                  call_ready,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car0_idle,
  input  logic                  car1_idle,
  input  logic                  car0_over_weight,
  input  logic                  car1_over_weight,
  output logic                  dispatch_valid,
  output logic                  dispatch_car,
  output logic [FLOOR_W-1:0]    dispatch_floor,
  input  logic                  dispatch_ready,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [7:0]            drop_count
);
  import elevator_pkg::*;

  dispatch_state_t       state_q;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [FLOOR_W-1:0]    rr_ptr_q;
  logic                  tie_tgl_q;
  logic                  dispatch_valid_q;
  car_id_t               dispatch_car_q;
  logic [FLOOR_W-1:0]    dispatch_floor_q;
  logic [7:0]            drop_q, drop_d;

  logic                  accept, handshake;
  logic                  pick_found;
  logic [FLOOR_W-1:0]    pick_floor;
  logic                  elig0, elig1;
  logic [FLOOR_W-1:0]    dist0, dist1;
  car_id_t               sel_car;
  logic                  is_tie;

  floor_rr_picker #(
    .FLOOR_W   (FLOOR_W),
    .NUM_FLOORS(NUM_FLOORS)
  ) u_picker (
    .pend_i  (pend_q),
    .rr_ptr_i(rr_ptr_q),
    .found_o (pick_found),
    .floor_o (pick_floor)
  );

  assign call_ready = !rst;
  assign accept     = call_valid && call_ready;
  assign handshake  = dispatch_valid_q && dispatch_ready;

  // Car selection: a lone eligible car wins outright; with both eligible
  // the nearer one wins and an exact tie goes to the alternating toggle.
  always_comb begin
    elig0   = car0_idle && !car0_over_weight;
    elig1   = car1_idle && !car1_over_weight;
    dist0   = (car0_floor > pick_floor) ? car0_floor - pick_floor : pick_floor - car0_floor;
    dist1   = (car1_floor > pick_floor) ? car1_floor - pick_floor : pick_floor - car1_floor;
    sel_car = 1'b0;
    is_tie  = 1'b0;
    if (elig0 && !elig1) begin
      sel_car = 1'b0;
    end else if (elig1 && !elig0) begin
      sel_car = 1'b1;
    end else if (dist0 < dist1) begin
      sel_car = 1'b0;
    end else if (dist1 < dist0) begin
      sel_car = 1'b1;
    end else begin
      is_tie  = 1'b1;
      sel_car = tie_tgl_q;
    end
  end

  // The clear on handshake comes after the set, so a call for the floor
  // being served in that same cycle is absorbed by the dispatch.
  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    if (accept) begin
      if (call_floor != '0) begin
        pend_d[call_floor] = 1'b1;
      end else if (drop_q != 8'(DROP_MAX)) begin
        drop_d = drop_q + 8'd1;
      end
    end
    if (handshake) begin
      pend_d[dispatch_floor_q] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      pend_q           <= '0;
      rr_ptr_q         <= '0;
      tie_tgl_q        <= 1'b0;
      dispatch_valid_q <= 1'b0;
      dispatch_car_q   <= 1'b0;
      dispatch_floor_q <= '0;
      drop_q           <= '0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      case (state_q)
        IDLE: begin
          if (pend_q != '0) state_q <= PICK;
        end
        PICK: begin
          if (!pick_found) begin
            state_q <= IDLE;
          end else if (elig0 || elig1) begin
            dispatch_car_q   <= sel_car;
            dispatch_floor_q <= pick_floor;
            dispatch_valid_q <= 1'b1;
            if (elig0 && elig1 && is_tie) tie_tgl_q <= !tie_tgl_q;
            state_q          <= ISSUE;
          end
        end
        ISSUE: begin
          // The offer is held regardless of the car's later status.
          if (dispatch_ready) begin
            dispatch_valid_q <= 1'b0;
            rr_ptr_q         <= dispatch_floor_q;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dispatch_valid = dispatch_valid_q;
  assign dispatch_car   = dispatch_car_q;
  assign dispatch_floor = dispatch_floor_q;
  assign pending        = pend_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_elevator_dispatch_scheduler.sv
// Self-checking bench for elevator_dispatch_scheduler: a transaction-level
// reference model tracks the call set, round-robin pointer and tie toggle,
// a vector table covers car selection, and hand-written sequences cover
// the multi-cycle corner cases; random traffic runs against the model.
module tb_elevator_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       call_valid = 1'b0;
  logic [2:0] call_floor = '0;
  logic       call_ready;
  logic [2:0] car0_floor = 3'd1;
  logic [2:0] car1_floor = 3'd7;
  logic       car0_idle = 1'b1;
  logic       car1_idle = 1'b1;
  logic       car0_over_weight = 1'b0;
  logic       car1_over_weight = 1'b0;
  logic       dispatch_valid;
  logic       dispatch_car;
  logic [2:0] dispatch_floor;
  logic       dispatch_ready = 1'b0;
  logic [7:0] pending;
  logic [7:0] drop_count;

  elevator_dispatch_scheduler #(.FLOOR_W(3), .NUM_FLOORS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .call_valid      (call_valid),
    .call_floor      (call_floor),
    .call_ready      (call_ready),
    .car0_floor      (car0_floor),
    .car1_floor      (car1_floor),
    .car0_idle       (car0_idle),
    .car1_idle       (car1_idle),
    .car0_over_weight(car0_over_weight),
    .car1_over_weight(car1_over_weight),
    .dispatch_valid  (dispatch_valid),
    .dispatch_car    (dispatch_car),
    .dispatch_floor  (dispatch_floor),
    .dispatch_ready  (dispatch_ready),
    .pending         (pending),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [7:0] m_pend;
  int       m_ptr, m_phase, m_car, m_fl, m_drop;
  bit       m_tie, m_dv;

  int hs_floor_q[$];
  int hs_car_q[$];

  typedef struct {
    int c0f; int c1f;
    bit c0i; bit c0o; bit c1i; bit c1o;
    int cf;  int ecar;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_phase = 0; m_car = 0; m_fl = 0;
    m_drop = 0; m_tie = 1'b0; m_dv = 1'b0;
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // One clock edge of the specified behaviour.
  task automatic model_step();
    bit hs;
    int served, f, sel, d0, d1;
    bit e0, e1;
    if (rst) begin
      model_reset();
      return;
    end
    hs = m_dv && dispatch_ready;
    served = m_fl;
    if (m_phase == 0) begin
      if (m_pend != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      f = 0;
      for (int k = 1; k <= 7; k++) begin
        int c;
        c = (m_ptr + k - 1) % 7 + 1;
        if (f == 0 && m_pend[c]) f = c;
      end
      e0 = car0_idle && !car0_over_weight;
      e1 = car1_idle && !car1_over_weight;
      if (f != 0 && (e0 || e1)) begin
        d0 = absdiff(int'(car0_floor), f);
        d1 = absdiff(int'(car1_floor), f);
        if (e0 && !e1) sel = 0;
        else if (e1 && !e0) sel = 1;
        else if (d0 < d1) sel = 0;
        else if (d1 < d0) sel = 1;
        else begin
          sel = int'(m_tie);
          m_tie = !m_tie;
        end
        m_car = sel; m_fl = f; m_dv = 1'b1; m_phase = 2;
      end else if (f == 0) begin
        m_phase = 0;
      end
    end else begin
      if (hs) begin
        m_dv = 1'b0; m_ptr = served; m_phase = 0;
      end
    end
    if (call_valid) begin
      if (call_floor == 0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_pend[call_floor] = 1'b1;
      end
    end
    if (hs) m_pend[served] = 1'b0;
  endtask

  task automatic compare_all();
    chk("call_ready", int'(call_ready), int'(!rst));
    chk("dispatch_valid", int'(dispatch_valid), int'(m_dv));
    chk("dispatch_car", int'(dispatch_car), m_car);
    chk("dispatch_floor", int'(dispatch_floor), m_fl);
    chk("pending", int'(pending), int'(m_pend));
    chk("drop_count", int'(drop_count), m_drop);
  endtask

  task automatic tick();
    if (dispatch_valid && dispatch_ready) begin
      hs_floor_q.push_back(int'(dispatch_floor));
      hs_car_q.push_back(int'(dispatch_car));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    call_valid = 1'b0;
    dispatch_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    hs_floor_q.delete();
    hs_car_q.delete();
  endtask

  task automatic set_cars(input int f0, input int f1, input bit i0, input bit o0,
                          input bit i1, input bit o1);
    car0_floor = 3'(f0); car1_floor = 3'(f1);
    car0_idle = i0; car0_over_weight = o0;
    car1_idle = i1; car1_over_weight = o1;
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = 3'(f);
    tick();
    call_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (!dispatch_valid && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_valid", int'(dispatch_valid), 1);
  endtask

  task automatic collect(input int n, input int maxc);
    int c;
    c = 0;
    while (hs_floor_q.size() < n && c < maxc) begin
      tick();
      c++;
    end
    chk("collect_count", hs_floor_q.size(), n);
  endtask

  initial begin
    tbl[0] = '{1, 7, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1};
    tbl[1] = '{1, 7, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0};
    tbl[2] = '{4, 4, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0};
    tbl[3] = '{2, 6, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0};
    tbl[4] = '{1, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1};
    tbl[5] = '{1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 7, 0};
    tbl[6] = '{7, 1, 1'b1, 1'b0, 1'b1, 1'b0, 7, 0};
    tbl[7] = '{3, 5, 1'b1, 1'b0, 1'b1, 1'b0, 6, 1};

    model_reset();
    do_reset();
    chk("reset_pending", int'(pending), 0);
    chk("reset_valid", int'(dispatch_valid), 0);

    // Table: single call, latency of two edges, then handshake.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_cars(tbl[i].c0f, tbl[i].c1f, tbl[i].c0i, tbl[i].c0o, tbl[i].c1i, tbl[i].c1o);
      call(tbl[i].cf);
      chk("tbl_pend_set", int'(pending[tbl[i].cf]), 1);
      tick();
      chk("tbl_lat1_valid", int'(dispatch_valid), 0);
      tick();
      chk("tbl_lat2_valid", int'(dispatch_valid), 1);
      chk("tbl_car", int'(dispatch_car), tbl[i].ecar);
      chk("tbl_floor", int'(dispatch_floor), tbl[i].cf);
      dispatch_ready = 1'b1;
      tick();
      dispatch_ready = 1'b0;
      chk("tbl_valid_after_hs", int'(dispatch_valid), 0);
      chk("tbl_pend_after_hs", int'(pending), 0);
    end

    // Round-robin order, then wrap past the top floor.
    do_reset();
    set_cars(1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    dispatch_ready = 1'b1;
    call(3); call(6); call(2);
    tick(); tick();
    car0_idle = 1'b1; car1_idle = 1'b1;
    collect(3, 40);
    if (hs_floor_q.size() >= 3) begin
      chk("rr_first", hs_floor_q[0], 2);
      chk("rr_second", hs_floor_q[1], 3);
      chk("rr_third", hs_floor_q[2], 6);
    end
    car0_idle = 1'b0; car1_idle = 1'b0;
    call(1); call(4);
    tick();
    car0_idle = 1'b1; car1_idle = 1'b1;
    collect(5, 40);
    if (hs_floor_q.size() >= 5) begin
      chk("rr_wrap_first", hs_floor_q[3], 1);
      chk("rr_wrap_second", hs_floor_q[4], 4);
    end
    dispatch_ready = 1'b0;

    // Tie alternation with both cars at floor 4.
    do_reset();
    set_cars(4, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    dispatch_ready = 1'b1;
    call(2);
    collect(1, 20);
    call(6);
    collect(2, 20);
    if (hs_car_q.size() >= 2) begin
      chk("tie_first_car", hs_car_q[0], 0);
      chk("tie_second_car", hs_car_q[1], 1);
    end
    dispatch_ready = 1'b0;

    // No eligible car: hold in PICK, then release.
    do_reset();
    set_cars(2, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    call(3);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_pick_valid", int'(dispatch_valid), 0);
    end
    car1_idle = 1'b1;
    wait_valid(5);
    chk("release_car", int'(dispatch_car), 1);
    chk("release_floor", int'(dispatch_floor), 3);

    // Offer stays stable while ready is low and eligibility drops.
    do_reset();
    set_cars(2, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    call(4);
    wait_valid(5);
    car0_idle = 1'b0; car1_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        call(4);
      end else begin
        tick();
      end
      chk("stable_valid", int'(dispatch_valid), 1);
      chk("stable_car", int'(dispatch_car), 1);
      chk("stable_floor", int'(dispatch_floor), 4);
    end
    car0_idle = 1'b1; car1_idle = 1'b1;
    dispatch_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("dup_single_dispatch", hs_floor_q.size(), 1);
    chk("dup_pending_clear", int'(pending), 0);
    dispatch_ready = 1'b0;

    // Floor-0 calls saturate the drop counter.
    do_reset();
    call_valid = 1'b1;
    call_floor = 3'd0;
    for (int i = 0; i < 300; i++) tick();
    call_valid = 1'b0;
    chk("drop_saturated", int'(drop_count), 255);
    chk("drop_no_pending", int'(pending), 0);

    // Asynchronous reset during an outstanding offer.
    do_reset();
    set_cars(1, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    call(3);
    call(5);
    wait_valid(5);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", int'(dispatch_valid), 0);
    chk("async_rst_pending", int'(pending), 0);
    chk("async_rst_ready", int'(call_ready), 0);
    tick();
    rst = 1'b0;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      call_valid = ($urandom % 3) == 0;
      call_floor = 3'($urandom % 8);
      if (($urandom % 8) == 0) begin
        car0_floor = 3'($urandom_range(1, 7));
        car1_floor = 3'($urandom_range(1, 7));
      end
      car0_idle = ($urandom % 4) != 0;
      car1_idle = ($urandom % 4) != 0;
      car0_over_weight = ($urandom % 6) == 0;
      car1_over_weight = ($urandom % 6) == 0;
      dispatch_ready = ($urandom % 2) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
